grid_row_clear: RTL

Parametrised ROWS×COLS grid row-clear engine. It accepts a board snapshot through a valid/ready handshake and repeatedly finds the highest-priority full row, with row 0 (top) winning. Each found row is removed by shifting every row above it down one position, and a zero row enters at the top. The engine returns the compacted board and a cleared-row count. It sits between the board-state register file and the scoring/display logic.

---
 rtl/grid_pkg.sv | 19 +
 rtl/row_prio_arb.sv | 14 +
 rtl/grid_row_clear.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/grid_pkg.sv
// Shared types and helpers for the grid row-clear engine.
package grid_pkg;

   localparam int ROWS_DEF = 3;
   localparam int COLS_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      CLEAR = 2'd2,
      DONE  = 2'd3
   } grid_state_e;

   // LSB position of row r in a packed board (row r lives at [r*cols +: cols]).
   function automatic int row_lsb(input int r, input int cols);
      return r * cols;
   endfunction

endpackage

// File: rtl/row_prio_arb.sv
// One-hot priority arbiter: the lowest set request bit wins. Purely combinational.
module row_prio_arb #(
   parameter int N = 3
) (
   input  logic [N-1:0] req_i,
   output logic [N-1:0] gnt_o
);

   // Two's-complement isolation of the lowest set bit.
   always_comb begin
      gnt_o = req_i & (~req_i + N'(1));
   end

endmodule

// File: rtl/grid_row_clear.sv
// Grid row-clear engine: repeatedly removes the topmost full row of a
// ROWS x COLS board, shifting the rows above it down and feeding in zeros.
// Build option: define ROW_CLEAR_COUNT_EN to maintain clear_count;
// otherwise no counter is built and clear_count reads 0.
//
// state | meaning
// IDLE  | in_ready high, waiting for a board
// SCAN  | look for the topmost full row
// CLEAR | remove the granted row (row_cleared pulses)
// DONE  | result held until out_ready
module grid_row_clear
   import grid_pkg::*;
#(
   parameter int ROWS  = ROWS_DEF,
   parameter int COLS  = COLS_DEF,
   parameter int CNT_W = $clog2(ROWS + 1)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [ROWS*COLS-1:0] cell_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ROWS*COLS-1:0] board_out,
   output logic [ROWS-1:0]      row_cleared,
   output logic [CNT_W-1:0]     clear_count
);

   grid_state_e            state_q, state_d;
   logic [ROWS*COLS-1:0]   board_q, board_d;
   // row_cleared_q doubles as the latched grant during CLEAR.
   logic [ROWS-1:0]        row_cleared_q, row_cleared_d;
   logic [ROWS-1:0]        full;
   logic [ROWS-1:0]        grant;
   logic [ROWS-1:0]        at_or_above;
   logic [ROWS*COLS-1:0]   shift_mask;
   logic [ROWS*COLS-1:0]   shifted;

   // Per-row fullness of the working board.
   always_comb begin
      full = '0;
      for (int r = 0; r < ROWS; r++) begin
         full[r] = &board_q[row_lsb(r, COLS) +: COLS];
      end
   end

   row_prio_arb #(.N(ROWS)) u_arb (
      .req_i (full),
      .gnt_o (grant)
   );

   // Rows 0..k take the row above them (row 0 takes zero); rows below k keep their value.
   always_comb begin
      at_or_above = '0;
      shift_mask  = '0;
      for (int r = 0; r < ROWS; r++) begin
         at_or_above[r] = |(row_cleared_q >> r);
         shift_mask[row_lsb(r, COLS) +: COLS] = {COLS{at_or_above[r]}};
      end
      shifted = ((board_q << COLS) & shift_mask) | (board_q & ~shift_mask);
   end

   // Next-state and registered-output decode.
   always_comb begin
      state_d       = state_q;
      board_d       = board_q;
      row_cleared_d = '0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               board_d = cell_in;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (grant == '0) begin
               state_d = DONE;
            end else begin
               row_cleared_d = grant;
               state_d       = CLEAR;
            end
         end
         CLEAR: begin
            board_d = shifted;
            state_d = SCAN;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, board and row-clear pulse registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         board_q       <= '0;
         row_cleared_q <= '0;
      end else begin
         state_q       <= state_d;
         board_q       <= board_d;
         row_cleared_q <= row_cleared_d;
      end
   end

`ifdef ROW_CLEAR_COUNT_EN
   logic [CNT_W-1:0] count_q, count_d;

   // Count zeroes on accept and steps once per removed row.
   always_comb begin
      count_d = count_q;
      if (state_q == IDLE && in_valid) begin
         count_d = '0;
      end else if (state_q == CLEAR) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Cleared-row counter register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign clear_count = count_q;
`else
   assign clear_count = '0;
`endif

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign board_out   = board_q;
   assign row_cleared = row_cleared_q;

endmodule
